// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, with start/done handshake
// Define SERIAL_SUB_OVF_EN to register signed overflow on ovf; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] count;
  logic borrow, d, bnew, last;
  assign d = a_sh[0] ^ b_sh[0] ^ borrow;
  assign bnew = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
  assign last = count == CW'(WIDTH - 1);
`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif
  // done trails the one-cycle DONE state so it coincides with settled diff/bout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      count <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      done <= state == DONE;
      case (state)
        RUN: begin
          diff <= {d, diff[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          borrow <= bnew;
          count <= count + 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            bout <= bnew;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= borrow ^ bnew;
`endif
          end
        end
        default: begin
          state <= start ? RUN : IDLE;
          if (start) begin
            busy <= 1'b1;
            a_sh <= a;
            b_sh <= b;
            borrow <= bin;
            count <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the bit-serial subtractor at WIDTH=8
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, bout, ovf;
  logic [7:0] diff;
  int tests = 0, fails = 0;
`ifdef SERIAL_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [7:0] VA [7] = '{8'h5A, 8'h10, 8'h00, 8'h3C, 8'h80, 8'h7F, 8'h05};
  localparam logic [7:0] VB [7] = '{8'h23, 8'h20, 8'h00, 8'h3C, 8'h01, 8'hFF, 8'h03};
  localparam logic       VC [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] VD [7] = '{8'h37, 8'hF0, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h02};
  localparam logic       VO [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic       VV [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic c, output int lat);
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (diff !== 8'h00) begin fails++; $display("FAIL reset_diff got %h want 00", diff); end
    tests++; if (bout !== 1'b0) begin fails++; $display("FAIL reset_bout got %b want 0", bout); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(VA[i], VB[i], VC[i], lat);
      tests++; if (lat !== 9) begin fails++; $display("FAIL vec%0d_latency got %0d want 9", i, lat); end
      tests++; if (diff !== VD[i]) begin fails++; $display("FAIL vec%0d_diff got %h want %h", i, diff, VD[i]); end
      tests++; if (bout !== VO[i]) begin fails++; $display("FAIL vec%0d_bout got %b want %b", i, bout, VO[i]); end
      tests++; if (ovf !== (VV[i] & OVF_EN)) begin fails++; $display("FAIL vec%0d_ovf got %b want %b", i, ovf, VV[i] & OVF_EN); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL vec%0d_busy_at_done got %b want 0", i, busy); end
      @(negedge clk);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL vec%0d_done_width got %b want 0", i, done); end
      tests++; if (diff !== VD[i]) begin fails++; $display("FAIL vec%0d_diff_hold got %h want %h", i, diff, VD[i]); end
    end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    logic [7:0] seen = '0;
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ignore_busy got %b want 1", busy); end
    for (int i = 0; i < 20; i++) begin
      if (done) begin pulses++; seen = diff; end
      @(negedge clk);
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    tests++; if (seen !== 8'h37) begin fails++; $display("FAIL ignore_diff got %h want 37", seen); end
    tests++; if (bout !== 1'b0) begin fails++; $display("FAIL ignore_bout got %b want 0", bout); end
  endtask

  task automatic test_reset_mid_run();
    int lat, pulses = 0;
    run_op(8'h00, 8'h01, 1'b0, lat);
    tests++; if (bout !== 1'b1) begin fails++; $display("FAIL pre_rst_bout got %b want 1", bout); end
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (diff !== 8'h00) begin fails++; $display("FAIL midrst_diff got %h want 00", diff); end
    tests++; if (bout !== 1'b0) begin fails++; $display("FAIL midrst_bout got %b want 0", bout); end
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL midrst_no_done got %0d want 0", pulses); end
    run_op(8'h05, 8'h03, 1'b0, lat);
    tests++; if (lat !== 9) begin fails++; $display("FAIL postrst_latency got %0d want 9", lat); end
    tests++; if (diff !== 8'h02) begin fails++; $display("FAIL postrst_diff got %h want 02", diff); end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h80; b = 8'h01;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    tests++; if (lat !== 9) begin fails++; $display("FAIL b2b_first_latency got %0d want 9", lat); end
    tests++; if (diff !== 8'h37) begin fails++; $display("FAIL b2b_first_diff got %h want 37", diff); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_rerun_busy got %b want 1", busy); end
    lat = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== 8) begin fails++; $display("FAIL b2b_spacing got %0d want 9", lat + 1); end
    tests++; if (diff !== 8'h7F) begin fails++; $display("FAIL b2b_second_diff got %h want 7f", diff); end
    tests++; if (bout !== 1'b0) begin fails++; $display("FAIL b2b_second_bout got %b want 0", bout); end
    tests++; if (ovf !== OVF_EN) begin fails++; $display("FAIL b2b_second_ovf got %b want %b", ovf, OVF_EN); end
    repeat (12) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_no_third got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
